tl_ul_sram_slave: RTL and testbench

- TL-UL slave endpoint on the 24 MHz side of the TL-UL clock-domain-crossing bridge.
- Consumes Channel A requests from the bridge's 24 MHz output and services them against a local word-organised SRAM.
- Returns one Channel D response per request into the bridge's 24 MHz Channel D input.
- Single-outstanding transaction engine: Get, PutFullData and PutPartialData, with error signalling.

---
 rtl/tl_ul_pkg.sv | 33 +++
 rtl/tl_ul_sram_array.sv | 35 +++
 rtl/tl_ul_sram_slave.sv | 257 +++++++++++++++++++++++++
 tb/tb_tl_ul_sram_slave.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_ul_pkg.sv
// tl_ul_pkg: shared TL-UL opcode constants, FSM state encoding and width
// defaults for the 24 MHz-side SRAM slave.
// Optional build macro: TL_UL_SRAM_WAIT_STATE_EN adds the ST_WAIT encoding.
package tl_ul_pkg;

    // Width / geometry defaults shared by the slave and its SRAM array
    localparam int TL_ADDR_WIDTH = 32;
    localparam int TL_DATA_WIDTH = 32;
    localparam int TL_SIZE_WIDTH = 3;
    localparam int TL_SRC_WIDTH  = 2;
    localparam int TL_SINK_WIDTH = 1;
    localparam int TL_MEM_WORDS  = 256;

    // Channel A opcodes
    localparam logic [2:0] TL_A_PUT_FULL    = 3'd0;
    localparam logic [2:0] TL_A_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] TL_A_GET         = 3'd4;

    // Channel D opcodes
    localparam logic [2:0] TL_D_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] TL_D_ACCESS_ACK_DATA = 3'd1;

    // Transaction engine states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
`ifdef TL_UL_SRAM_WAIT_STATE_EN
        ST_WAIT   = 2'd3,
`endif
        ST_RESP   = 2'd2
    } state_e;

endpackage

// File: rtl/tl_ul_sram_array.sv
// tl_ul_sram_array: single-port MEM_WORDS x DATA_WIDTH SRAM with byte-lane
// write enables and a registered read port. Contents are never reset.
module tl_ul_sram_array #(
    parameter  int DATA_WIDTH = 32,
    parameter  int MEM_WORDS  = 256,
    localparam int MASK_WIDTH = DATA_WIDTH / 8,
    localparam int IDX_BITS   = $clog2(MEM_WORDS)
) (
    input  logic                  i_clk,
    input  logic                  i_en,
    input  logic                  i_we,
    input  logic [IDX_BITS-1:0]   i_addr,
    input  logic [MASK_WIDTH-1:0] i_be,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];

    // Byte-lane write or synchronous read of one word per enabled cycle
    always_ff @(posedge i_clk) begin
        if (i_en) begin
            if (i_we) begin
                for (int b = 0; b < MASK_WIDTH; b++) begin
                    if (i_be[b]) begin
                        r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                    end
                end
            end else begin
                o_rdata <= r_mem[i_addr];
            end
        end
    end

endmodule

// File: rtl/tl_ul_sram_slave.sv
// tl_ul_sram_slave: single-outstanding TL-UL slave servicing Get /
// PutFullData / PutPartialData against a local word-organised SRAM.
// Optional build macro: TL_UL_SRAM_WAIT_STATE_EN inserts a WAIT state of
// WAIT_CYCLES (minimum one cycle) between ACCESS and RESP.
module tl_ul_sram_slave
    import tl_ul_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = TL_ADDR_WIDTH,
    parameter int                    DATA_WIDTH  = TL_DATA_WIDTH,
    parameter int                    MASK_WIDTH  = DATA_WIDTH / 8,
    parameter int                    SIZE_WIDTH  = TL_SIZE_WIDTH,
    parameter int                    SRC_WIDTH   = TL_SRC_WIDTH,
    parameter int                    SINK_WIDTH  = TL_SINK_WIDTH,
    parameter int                    MEM_WORDS   = TL_MEM_WORDS,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(32'h1000_0000),
    parameter int                    WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [2:0]            a_opcode,
    input  logic [2:0]            a_param,
    input  logic [SIZE_WIDTH-1:0] a_size,
    input  logic [SRC_WIDTH-1:0]  a_source,
    input  logic [ADDR_WIDTH-1:0] a_address,
    input  logic [MASK_WIDTH-1:0] a_mask,
    input  logic [DATA_WIDTH-1:0] a_data,
    output logic                  d_valid,
    input  logic                  d_ready,
    output logic [2:0]            d_opcode,
    output logic [2:0]            d_param,
    output logic [SIZE_WIDTH-1:0] d_size,
    output logic [SRC_WIDTH-1:0]  d_source,
    output logic [SINK_WIDTH-1:0] d_sink,
    output logic [DATA_WIDTH-1:0] d_data,
    output logic                  d_error
);

    localparam int                    LANE_BITS = $clog2(MASK_WIDTH);
    localparam int                    IDX_BITS  = $clog2(MEM_WORDS);
    localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_WORDS * MASK_WIDTH);

    // Byte lanes a PutFullData must enable for a given size and lane offset
    function automatic logic [MASK_WIDTH-1:0] full_lanes(
        input logic [SIZE_WIDTH-1:0] size,
        input logic [LANE_BITS-1:0]  lsb
    );
        logic [MASK_WIDTH-1:0] m;
        m = {MASK_WIDTH{1'b0}};
        for (int i = 0; i < MASK_WIDTH; i++) begin
            if ((i >= int'(lsb)) && (i < int'(lsb) + int'(32'd1 << size))) begin
                m[i] = 1'b1;
            end else begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

    state_e                r_state;
    state_e                w_state_next;
    logic                  r_a_ready;

    logic [2:0]            r_opcode;
    logic [SIZE_WIDTH-1:0] r_size;
    logic [SRC_WIDTH-1:0]  r_source;
    logic [IDX_BITS-1:0]   r_idx;
    logic [MASK_WIDTH-1:0] r_mask;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_err;

    logic                  r_d_valid;
    logic [2:0]            r_d_opcode;
    logic [SIZE_WIDTH-1:0] r_d_size;
    logic [SRC_WIDTH-1:0]  r_d_source;
    logic [DATA_WIDTH-1:0] r_d_data;
    logic                  r_d_error;

    logic                  w_a_fire;
    logic [ADDR_WIDTH-1:0] w_offset;
    logic [LANE_BITS-1:0]  w_lsb;
    logic                  w_bad_range;
    logic                  w_bad_opcode;
    logic                  w_bad_size;
    logic                  w_bad_align;
    logic                  w_bad_mask;
    logic                  w_err;
    logic                  w_mem_en;
    logic                  w_mem_we;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_unused;

    assign w_a_fire = a_valid && r_a_ready;
    assign w_offset = a_address - BASE_ADDR;
    assign w_lsb    = a_address[LANE_BITS-1:0];

    // Request legality: range (unsigned, so below-base wraps high), size,
    // alignment and PutFullData lane coverage
    assign w_bad_range = (w_offset >= MEM_BYTES);
    assign w_bad_size  = (a_size > SIZE_WIDTH'(LANE_BITS));
    assign w_bad_align = ((32'(w_lsb) & ((32'd1 << a_size) - 32'd1)) != 32'd0);
    assign w_bad_mask  = (a_opcode == TL_A_PUT_FULL) && (a_mask != full_lanes(a_size, w_lsb));
    assign w_err       = w_bad_range || w_bad_opcode || w_bad_size || w_bad_align || w_bad_mask;

    // Opcode decode: only Get and the two Put flavours are supported
    always_comb begin
        w_bad_opcode = 1'b1;
        case (a_opcode)
            TL_A_PUT_FULL, TL_A_PUT_PARTIAL, TL_A_GET: w_bad_opcode = 1'b0;
            default:                                   w_bad_opcode = 1'b1;
        endcase
    end

`ifdef TL_UL_SRAM_WAIT_STATE_EN
    localparam int WAIT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;

    logic [WAIT_W-1:0] r_wait_cnt;

    // Extra-latency down-counter, loaded while the SRAM access happens
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wait_cnt <= {WAIT_W{1'b0}};
        end else if (r_state == ST_ACCESS) begin
            r_wait_cnt <= WAIT_W'(WAIT_CYCLES);
        end else if ((r_state == ST_WAIT) && (r_wait_cnt != {WAIT_W{1'b0}})) begin
            r_wait_cnt <= r_wait_cnt - WAIT_W'(1);
        end
    end

    assign w_unused = ^a_param;
`else
    assign w_unused = ^{a_param, 32'(WAIT_CYCLES)};
`endif

    // Next-state logic of the transaction engine
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_a_fire) begin
                    w_state_next = ST_ACCESS;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
`ifdef TL_UL_SRAM_WAIT_STATE_EN
            ST_ACCESS: w_state_next = ST_WAIT;
            ST_WAIT: begin
                if (r_wait_cnt <= WAIT_W'(1)) begin
                    w_state_next = ST_RESP;
                end else begin
                    w_state_next = ST_WAIT;
                end
            end
`else
            ST_ACCESS: w_state_next = ST_RESP;
`endif
            ST_RESP: begin
                if (r_d_valid && d_ready) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_RESP;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State register plus registered a_ready (low in reset, high in IDLE)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_a_ready <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_a_ready <= (w_state_next == ST_IDLE);
        end
    end

    // Capture the accepted request and its legality verdict
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_opcode <= 3'd0;
            r_size   <= {SIZE_WIDTH{1'b0}};
            r_source <= {SRC_WIDTH{1'b0}};
            r_idx    <= {IDX_BITS{1'b0}};
            r_mask   <= {MASK_WIDTH{1'b0}};
            r_data   <= {DATA_WIDTH{1'b0}};
            r_err    <= 1'b0;
        end else if (w_a_fire) begin
            r_opcode <= a_opcode;
            r_size   <= a_size;
            r_source <= a_source;
            r_idx    <= w_offset[LANE_BITS +: IDX_BITS];
            r_mask   <= a_mask;
            r_data   <= a_data;
            r_err    <= w_err;
        end
    end

    // Errored requests never touch the array; legal non-Get ops are writes
    assign w_mem_en = (r_state == ST_ACCESS) && !r_err;
    assign w_mem_we = (r_opcode != TL_A_GET);

    tl_ul_sram_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_WORDS  (MEM_WORDS)
    ) u_array (
        .i_clk   (clk),
        .i_en    (w_mem_en),
        .i_we    (w_mem_we),
        .i_addr  (r_idx),
        .i_be    (r_mask),
        .i_wdata (r_data),
        .o_rdata (w_rdata)
    );

    // Response register: loads on the first RESP cycle, holds until accepted
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_d_valid  <= 1'b0;
            r_d_opcode <= 3'd0;
            r_d_size   <= {SIZE_WIDTH{1'b0}};
            r_d_source <= {SRC_WIDTH{1'b0}};
            r_d_data   <= {DATA_WIDTH{1'b0}};
            r_d_error  <= 1'b0;
        end else if (r_state == ST_RESP) begin
            if (!r_d_valid) begin
                r_d_valid  <= 1'b1;
                r_d_opcode <= (r_opcode == TL_A_GET) ? TL_D_ACCESS_ACK_DATA : TL_D_ACCESS_ACK;
                r_d_size   <= r_size;
                r_d_source <= r_source;
                r_d_data   <= ((r_opcode == TL_A_GET) && !r_err) ? w_rdata : {DATA_WIDTH{1'b0}};
                r_d_error  <= r_err;
            end else if (d_ready) begin
                r_d_valid  <= 1'b0;
                r_d_opcode <= 3'd0;
                r_d_size   <= {SIZE_WIDTH{1'b0}};
                r_d_source <= {SRC_WIDTH{1'b0}};
                r_d_data   <= {DATA_WIDTH{1'b0}};
                r_d_error  <= 1'b0;
            end
        end
    end

    assign a_ready  = r_a_ready;
    assign d_valid  = r_d_valid;
    assign d_opcode = r_d_opcode;
    assign d_param  = 3'd0;
    assign d_size   = r_d_size;
    assign d_source = r_d_source;
    assign d_sink   = {SINK_WIDTH{1'b0}};
    assign d_data   = r_d_data;
    assign d_error  = r_d_error;

endmodule

// File: tb/tb_tl_ul_sram_slave.sv
// tb_tl_ul_sram_slave: scoreboard bench for the TL-UL SRAM slave.
// Expected responses are queued at request issue and compared on collection.
module tb_tl_ul_sram_slave;

`ifdef TL_UL_SRAM_WAIT_STATE_EN
    localparam int EXP_LAT = 4;
`else
    localparam int EXP_LAT = 2;
`endif

    typedef struct packed {
        logic [2:0]  opcode;
        logic [2:0]  param;
        logic        error;
        logic [2:0]  size;
        logic [1:0]  source;
        logic [0:0]  sink;
        logic [31:0] data;
    } rsp_t;

    typedef struct packed {
        logic [2:0]  op;
        logic [2:0]  sz;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
        rsp_t        exp;
    } req_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [2:0]  a_size;
    logic [1:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_valid;
    logic        d_ready;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [2:0]  d_size;
    logic [1:0]  d_source;
    logic [0:0]  d_sink;
    logic [31:0] d_data;
    logic        d_error;

    int   checks   = 0;
    int   failures = 0;
    rsp_t sb [$];

    tl_ul_sram_slave dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_opcode  (a_opcode),
        .a_param   (a_param),
        .a_size    (a_size),
        .a_source  (a_source),
        .a_address (a_address),
        .a_mask    (a_mask),
        .a_data    (a_data),
        .d_valid   (d_valid),
        .d_ready   (d_ready),
        .d_opcode  (d_opcode),
        .d_param   (d_param),
        .d_size    (d_size),
        .d_source  (d_source),
        .d_sink    (d_sink),
        .d_data    (d_data),
        .d_error   (d_error)
    );

    always #5 clk = ~clk;

    function automatic rsp_t mk(input logic [2:0] op, input logic err, input logic [2:0] sz,
                                input logic [1:0] src, input logic [31:0] data);
        rsp_t r;
        r.opcode = op;
        r.param  = 3'd0;
        r.error  = err;
        r.size   = sz;
        r.source = src;
        r.sink   = 1'b0;
        r.data   = data;
        return r;
    endfunction

    function automatic req_t mk_req(input logic [2:0] op, input logic [2:0] sz, input logic [31:0] addr,
                                    input logic [3:0] mask, input logic [31:0] data, input rsp_t exp);
        req_t q;
        q.op   = op;
        q.sz   = sz;
        q.addr = addr;
        q.mask = mask;
        q.data = data;
        q.exp  = exp;
        return q;
    endfunction

    function automatic rsp_t sample_d();
        rsp_t r;
        r.opcode = d_opcode;
        r.param  = d_param;
        r.error  = d_error;
        r.size   = d_size;
        r.source = d_source;
        r.sink   = d_sink;
        r.data   = d_data;
        return r;
    endfunction

    // Present a request, wait (bounded) for a_ready, handshake, queue expectation
    task automatic issue(input logic [2:0] op, input logic [2:0] sz, input logic [1:0] src,
                         input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data,
                         input rsp_t exp);
        int n;
        a_opcode  = op;
        a_size    = sz;
        a_source  = src;
        a_address = addr;
        a_mask    = mask;
        a_data    = data;
        a_param   = 3'd5;
        a_valid   = 1'b1;
        n = 0;
        while ((a_ready !== 1'b1) && (n < 40)) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (a_ready !== 1'b1) begin
            failures++;
            $display("FAIL a_ready_timeout got=%b exp=1", a_ready);
            a_valid = 1'b0;
        end else begin
            @(posedge clk);
            sb.push_back(exp);
            #1;
            a_valid = 1'b0;
        end
    endtask

    // Wait (bounded) for d_valid, sample the response, then accept it
    task automatic collect(output rsp_t obs, output int lat);
        lat = 0;
        while ((d_valid !== 1'b1) && (lat < 40)) begin
            @(posedge clk); #1;
            lat++;
        end
        obs = sample_d();
        if (d_valid === 1'b1) begin
            d_ready = 1'b1;
            @(posedge clk); #1;
            d_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        #3 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (a_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_a_ready got=%b exp=0", a_ready);
        end
        checks++;
        if ({d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error} !== 46'd0) begin
            failures++;
            $display("FAIL reset_d_fields got=%h exp=0",
                     {d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error});
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (a_ready !== 1'b1) begin
            failures++;
            $display("FAIL release_a_ready got=%b exp=1", a_ready);
        end
    endtask

    // Run a list of transactions one at a time, checking response and latency
    task automatic run_table(input string name, input req_t tbl [$], input logic [1:0] src);
        rsp_t obs;
        rsp_t exp;
        int   lat;
        foreach (tbl[i]) begin
            issue(tbl[i].op, tbl[i].sz, src, tbl[i].addr, tbl[i].mask, tbl[i].data, tbl[i].exp);
            collect(obs, lat);
            exp = sb.pop_front();
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL %s_rsp[%0d] got=%h exp=%h", name, i, obs, exp);
            end
            checks++;
            if (lat !== EXP_LAT) begin
                failures++;
                $display("FAIL %s_latency[%0d] got=%0d exp=%0d", name, i, lat, EXP_LAT);
            end
        end
    endtask

    task automatic test_put_get();
        req_t t [$];
        t.push_back(mk_req(3'd0, 3'd2, 32'h1000_0010, 4'hF, 32'hDEAD_BEEF, mk(3'd0, 1'b0, 3'd2, 2'd2, 32'h0)));
        t.push_back(mk_req(3'd4, 3'd2, 32'h1000_0010, 4'hF, 32'h0,         mk(3'd1, 1'b0, 3'd2, 2'd2, 32'hDEAD_BEEF)));
        run_table("put_get", t, 2'd2);
    endtask

    task automatic test_partial();
        req_t t [$];
        t.push_back(mk_req(3'd1, 3'd2, 32'h1000_0010, 4'h6, 32'h1122_3344, mk(3'd0, 1'b0, 3'd2, 2'd1, 32'h0)));
        t.push_back(mk_req(3'd4, 3'd2, 32'h1000_0010, 4'hF, 32'h0,         mk(3'd1, 1'b0, 3'd2, 2'd1, 32'hDE22_33EF)));
        t.push_back(mk_req(3'd0, 3'd1, 32'h1000_0012, 4'hC, 32'hAAAA_0000, mk(3'd0, 1'b0, 3'd1, 2'd1, 32'h0)));
        t.push_back(mk_req(3'd0, 3'd0, 32'h1000_0013, 4'h8, 32'h5500_0000, mk(3'd0, 1'b0, 3'd0, 2'd1, 32'h0)));
        t.push_back(mk_req(3'd4, 3'd2, 32'h1000_0010, 4'hF, 32'h0,         mk(3'd1, 1'b0, 3'd2, 2'd1, 32'h55AA_33EF)));
        run_table("partial", t, 2'd1);
    endtask

    task automatic test_errors();
        req_t t [$];
        t.push_back(mk_req(3'd4, 3'd2, 32'h1000_0400, 4'hF, 32'h0,         mk(3'd1, 1'b1, 3'd2, 2'd3, 32'h0)));
        t.push_back(mk_req(3'd4, 3'd2, 32'h1000_0011, 4'hF, 32'h0,         mk(3'd1, 1'b1, 3'd2, 2'd3, 32'h0)));
        t.push_back(mk_req(3'd0, 3'd2, 32'h1000_0011, 4'hF, 32'h0,         mk(3'd0, 1'b1, 3'd2, 2'd3, 32'h0)));
        t.push_back(mk_req(3'd2, 3'd2, 32'h1000_0010, 4'hF, 32'h0,         mk(3'd0, 1'b1, 3'd2, 2'd3, 32'h0)));
        t.push_back(mk_req(3'd4, 3'd3, 32'h1000_0010, 4'hF, 32'h0,         mk(3'd1, 1'b1, 3'd3, 2'd3, 32'h0)));
        t.push_back(mk_req(3'd0, 3'd2, 32'h1000_0010, 4'h3, 32'h0,         mk(3'd0, 1'b1, 3'd2, 2'd3, 32'h0)));
        t.push_back(mk_req(3'd0, 3'd2, 32'h1000_0410, 4'hF, 32'h0,         mk(3'd0, 1'b1, 3'd2, 2'd3, 32'h0)));
        t.push_back(mk_req(3'd4, 3'd2, 32'h0FFF_FFFC, 4'hF, 32'h0,         mk(3'd1, 1'b1, 3'd2, 2'd3, 32'h0)));
        t.push_back(mk_req(3'd0, 3'd2, 32'h1000_03FC, 4'hF, 32'hA5A5_5A5A, mk(3'd0, 1'b0, 3'd2, 2'd3, 32'h0)));
        t.push_back(mk_req(3'd4, 3'd2, 32'h1000_03FC, 4'hF, 32'h0,         mk(3'd1, 1'b0, 3'd2, 2'd3, 32'hA5A5_5A5A)));
        t.push_back(mk_req(3'd4, 3'd2, 32'h1000_0010, 4'hF, 32'h0,         mk(3'd1, 1'b0, 3'd2, 2'd3, 32'h55AA_33EF)));
        run_table("errors", t, 2'd3);
    endtask

    task automatic test_latency();
        rsp_t obs;
        rsp_t exp;
        int   lat;
        issue(3'd4, 3'd2, 2'd0, 32'h1000_0010, 4'hF, 32'h0, mk(3'd1, 1'b0, 3'd2, 2'd0, 32'h55AA_33EF));
        checks++;
        if ((a_ready !== 1'b0) || (d_valid !== 1'b0)) begin
            failures++;
            $display("FAIL latency_busy got=a_ready:%b d_valid:%b exp=0,0", a_ready, d_valid);
        end
        collect(obs, lat);
        exp = sb.pop_front();
        checks++;
        if (lat !== EXP_LAT) begin
            failures++;
            $display("FAIL latency_cycles got=%0d exp=%0d", lat, EXP_LAT);
        end
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL latency_rsp got=%h exp=%h", obs, exp);
        end
    endtask

    task automatic test_backpressure();
        rsp_t exp;
        int   n;
        issue(3'd4, 3'd2, 2'd2, 32'h1000_03FC, 4'hF, 32'h0, mk(3'd1, 1'b0, 3'd2, 2'd2, 32'hA5A5_5A5A));
        exp = sb.pop_front();
        n = 0;
        while ((d_valid !== 1'b1) && (n < 40)) begin
            @(posedge clk); #1;
            n++;
        end
        for (int c = 0; c < 10; c++) begin
            checks++;
            if ((d_valid !== 1'b1) || (sample_d() !== exp)) begin
                failures++;
                $display("FAIL hold_rsp[%0d] got=%b/%h exp=1/%h", c, d_valid, sample_d(), exp);
            end
            checks++;
            if (a_ready !== 1'b0) begin
                failures++;
                $display("FAIL hold_a_ready[%0d] got=%b exp=0", c, a_ready);
            end
            @(posedge clk); #1;
        end
        d_ready = 1'b1;
        @(posedge clk); #1;
        d_ready = 1'b0;
        checks++;
        if ((d_valid !== 1'b0) || (a_ready !== 1'b1)) begin
            failures++;
            $display("FAIL release_handshake got=d_valid:%b a_ready:%b exp=0,1", d_valid, a_ready);
        end
    endtask

    task automatic test_reset_mid();
        rsp_t obs;
        rsp_t exp;
        int   lat;
        logic stale;
        issue(3'd0, 3'd2, 2'd1, 32'h1000_0020, 4'hF, 32'hCAFE_F00D, mk(3'd0, 1'b0, 3'd2, 2'd1, 32'h0));
        collect(obs, lat);
        exp = sb.pop_front();
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL mid_prewrite got=%h exp=%h", obs, exp);
        end
        // Request accepted; DUT now sits in ACCESS when reset hits
        issue(3'd0, 3'd2, 2'd1, 32'h1000_0020, 4'hF, 32'h1234_5678, mk(3'd0, 1'b0, 3'd2, 2'd1, 32'h0));
        reset_n = 1'b0;
        #1;
        checks++;
        if ((d_valid !== 1'b0) || (a_ready !== 1'b0)) begin
            failures++;
            $display("FAIL mid_reset_outputs got=d_valid:%b a_ready:%b exp=0,0", d_valid, a_ready);
        end
        sb.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (a_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_release_a_ready got=%b exp=1", a_ready);
        end
        stale = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (d_valid !== 1'b0) stale = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (stale !== 1'b0) begin
            failures++;
            $display("FAIL mid_stale_response got=%b exp=0", stale);
        end
        issue(3'd4, 3'd2, 2'd1, 32'h1000_0020, 4'hF, 32'h0, mk(3'd1, 1'b0, 3'd2, 2'd1, 32'hCAFE_F00D));
        collect(obs, lat);
        exp = sb.pop_front();
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL mid_write_lost got=%h exp=%h", obs, exp);
        end
    endtask

    initial begin
        a_valid   = 1'b0;
        a_opcode  = 3'd0;
        a_param   = 3'd0;
        a_size    = 3'd0;
        a_source  = 2'd0;
        a_address = 32'h0;
        a_mask    = 4'h0;
        a_data    = 32'h0;
        d_ready   = 1'b0;
        reset_n   = 1'b1;
        test_reset();
        test_put_get();
        test_partial();
        test_errors();
        test_latency();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
